// File: rtl/pipeline_stall_controller.sv
// Decode-stage hazard scheduler: load-use, branch-compare and HI/LO-read stalls,
// branch-compare forwarding from M, mult/div busy sequencing and a stall counter.
module pipeline_stall_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rs_d,
  input  logic [4:0]        rt_d,
  input  logic              branch_d,
  input  logic              pcsrc_d,
  input  logic              mfhilo_d,
  input  logic              mdop_d,
  input  logic [4:0]        writereg_ex,
  input  logic              regwrite_ex,
  input  logic              memtoreg_ex,
  input  logic [4:0]        writereg_mem,
  input  logic              regwrite_mem,
  input  logic              memtoreg_mem,
  input  logic              md_start_ex,
  input  logic              md_is_div_ex,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              forward_a_d,
  output logic              forward_b_d,
  output logic              md_busy,
  output logic              md_done,
  output logic [PERF_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  md_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              md_busy_q;
  logic              md_done_q;
  logic [PERF_W-1:0] stall_count_q;
  logic [PERF_W-1:0] stall_count_d;

  logic ex_hit;
  logic mem_load_hit;
  logic lwstall;
  logic branchstall;
  logic mdstall;
  logic stall;

  always_comb begin
    forward_a_d  = (rs_d != 5'd0) && (rs_d == writereg_mem) && regwrite_mem;
    forward_b_d  = (rt_d != 5'd0) && (rt_d == writereg_mem) && regwrite_mem;

    ex_hit       = (writereg_ex != 5'd0) &&
                   ((writereg_ex == rs_d) || (writereg_ex == rt_d));
    mem_load_hit = memtoreg_mem && (writereg_mem != 5'd0) &&
                   ((writereg_mem == rs_d) || (writereg_mem == rt_d));

    lwstall      = memtoreg_ex && ex_hit;
    branchstall  = branch_d && ((regwrite_ex && ex_hit) || mem_load_hit);
    // The done cycle releases the reader so it reaches E after HI/LO are written.
    mdstall      = (mfhilo_d || mdop_d) && md_busy_q && !md_done_q;
    stall        = lwstall || branchstall || mdstall;

    stall_f      = stall;
    stall_d      = stall;
    flush_e      = stall;
    flush_d      = pcsrc_d && !stall;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {PERF_W{1'b1}})) begin
      stall_count_d = stall_count_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  // Busy/done are registered alongside the state so they come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (md_start_ex) begin
            state_q   <= ST_BUSY;
            cnt_q     <= md_is_div_ex ? DIV_LOAD : MULT_LOAD;
            md_busy_q <= 1'b1;
            md_done_q <= md_is_div_ex ? (DIV_LOAD == '0) : (MULT_LOAD == '0);
          end else begin
            md_busy_q <= 1'b0;
            md_done_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) begin
            state_q   <= ST_IDLE;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b0;
          end else begin
            cnt_q     <= cnt_q - CNT_W'(1);
            md_busy_q <= 1'b1;
            md_done_q <= (cnt_q == CNT_W'(1));
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          md_busy_q <= 1'b0;
          md_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy     = md_busy_q;
  assign md_done     = md_done_q;
  assign stall_count = stall_count_q;

endmodule
